// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM capture block.
//   CntW            default tick counter width
//   PosW            width of the position value (generator input domain)
//   DefClkDiv       default clk cycles per measurement tick
//   DefPosOffset    default ticks removed from the high time to form a position
//   DefPosMax       default upper clamp of the position value
//   DefTimeoutTicks default ticks without an edge before timeout
//   StabCycles      clk cycles a new level must hold to pass the glitch filter
package pwm_pkg;

  localparam int unsigned CntW            = 12;
  localparam int unsigned PosW            = 11;
  localparam int unsigned DefClkDiv       = 100;
  localparam int unsigned DefPosOffset    = 1000;
  localparam int unsigned DefPosMax       = 2047;
  localparam int unsigned DefTimeoutTicks = 4000;
  localparam int unsigned StabCycles      = 8;

  typedef enum logic [1:0] {
    WaitRise,
    MeasHigh,
    MeasLow
  } pwm_cap_state_t;

endpackage

// File: rtl/pwm_in_cond.sv
// Input conditioning for an asynchronous PWM line.
// Two-flop synchronizer, optional stability filter, then registered rise/fall
// strobes (one clk each, 3 clk after the input change when unfiltered).
// Build option: define GLITCH_FILTER_EN to insert the stability filter, which
// only accepts a new level after it has been stable for StabCycles clk.
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous reset, active-low
//   pwm_in in  asynchronous PWM input
//   rise   out one-clk strobe on a conditioned rising edge
//   fall   out one-clk strobe on a conditioned falling edge
module pwm_in_cond
  import pwm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync2_q;
  logic lvl;
  logic lvl_q, rise_q, fall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

`ifdef GLITCH_FILTER_EN
  logic       filt_q;
  logic [2:0] stab_q;

  // Count consecutive clk where the synchronized input disagrees with the
  // accepted level; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else if (sync2_q != filt_q) begin
      if (stab_q == 3'(StabCycles - 1)) begin
        filt_q <= sync2_q;
        stab_q <= '0;
      end else begin
        stab_q <= stab_q + 1'b1;
      end
    end else begin
      stab_q <= '0;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      lvl_q  <= lvl;
      rise_q <= lvl & ~lvl_q;
      fall_q <= ~lvl & lvl_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and rise-to-rise period of an incoming PWM
// line in prescaled ticks and converts the high time into a position value.
// Build option: GLITCH_FILTER_EN (see pwm_in_cond) adds an input stability filter.
// Ports:
//   clk          in  system clock
//   rst          in  asynchronous reset, active-low
//   pwm_in       in  asynchronous PWM input
//   width_ticks  out high time of the last complete period, in ticks
//   period_ticks out rise-to-rise time of the last complete period, in ticks
//   pos_val      out clamp(width_ticks - POS_OFFSET, 0, POS_MAX)
//   valid        out one-clk pulse when the three outputs above update
//   timeout      out level, no edge seen for TIMEOUT_TICKS ticks
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV       = DefClkDiv,
  parameter int unsigned CNT_W         = CntW,
  parameter int unsigned POS_OFFSET    = DefPosOffset,
  parameter int unsigned POS_MAX       = DefPosMax,
  parameter int unsigned TIMEOUT_TICKS = DefTimeoutTicks
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] width_ticks,
  output logic [CNT_W-1:0] period_ticks,
  output logic [PosW-1:0]  pos_val,
  output logic             valid,
  output logic             timeout
);

  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IdleW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic signed [CNT_W:0] PosOffsetS = (CNT_W + 1)'(POS_OFFSET);
  localparam logic signed [CNT_W:0] PosMaxS    = (CNT_W + 1)'(POS_MAX);

  logic rise, fall;

  pwm_in_cond u_in_cond (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .rise   (rise),
    .fall   (fall)
  );

  pwm_cap_state_t   state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [CNT_W-1:0] hi_q, hi_d, per_q, per_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [CNT_W-1:0] width_q, width_d, period_q, period_d;
  logic [PosW-1:0]  pos_q, pos_d;
  logic             valid_q, valid_d, timeout_q, timeout_d;

  logic                    tick, idle_hit;
  logic signed [CNT_W:0]   pos_diff;
  logic [PosW-1:0]         pos_clamped;

  // Free-running prescaler; never re-phased on edges.
  assign tick     = (div_q == DivW'(CLK_DIV - 1));
  assign div_d    = tick ? '0 : div_q + 1'b1;
  assign idle_hit = (idle_q == IdleW'(TIMEOUT_TICKS));

  always_comb begin
    pos_diff = $signed({1'b0, hi_q}) - PosOffsetS;
    if (pos_diff < 0) begin
      pos_clamped = '0;
    end else if (pos_diff > PosMaxS) begin
      pos_clamped = PosW'(POS_MAX);
    end else begin
      pos_clamped = PosW'(pos_diff);
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    per_d     = per_q;
    width_d   = width_q;
    period_d  = period_q;
    pos_d     = pos_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    // Idle counter holds at the threshold until the next edge.
    if (rise || fall) begin
      idle_d = '0;
    end else if (tick && !idle_hit) begin
      idle_d = idle_q + 1'b1;
    end else begin
      idle_d = idle_q;
    end

    case (state_q)
      WaitRise: begin
        if (rise) begin
          hi_d    = '0;
          per_d   = '0;
          state_d = MeasHigh;
        end
      end
      MeasHigh: begin
        // The high count stops on the fall strobe; the period keeps its tick.
        if (tick && !(&per_q)) per_d = per_q + 1'b1;
        if (fall) begin
          state_d = MeasLow;
        end else if (tick && !(&hi_q)) begin
          hi_d = hi_q + 1'b1;
        end
      end
      MeasLow: begin
        if (rise) begin
          // Capture pre-increment counts; a coincident tick is dropped.
          width_d   = hi_q;
          period_d  = per_q;
          pos_d     = pos_clamped;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          hi_d      = '0;
          per_d     = '0;
          state_d   = MeasHigh;
        end else if (tick && !(&per_q)) begin
          per_d = per_q + 1'b1;
        end
      end
      default: state_d = WaitRise;
    endcase

    // Timeout abandons any measurement in progress; held outputs stay.
    if (idle_hit) begin
      timeout_d = 1'b1;
      if (state_q != WaitRise) begin
        state_d  = WaitRise;
        valid_d  = 1'b0;
        width_d  = width_q;
        period_d = period_q;
        pos_d    = pos_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= WaitRise;
      div_q     <= '0;
      hi_q      <= '0;
      per_q     <= '0;
      idle_q    <= '0;
      width_q   <= '0;
      period_q  <= '0;
      pos_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      hi_q      <= hi_d;
      per_q     <= per_d;
      idle_q    <= idle_d;
      width_q   <= width_d;
      period_q  <= period_d;
      pos_q     <= pos_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign width_ticks  = width_q;
  assign period_ticks = period_q;
  assign pos_val      = pos_q;
  assign valid        = valid_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture with CLK_DIV=4 and TIMEOUT_TICKS=4000.
// Expected measurements are queued when the closing rise of a period is driven
// and compared when valid pulses.
module tb_pwm_capture;

  localparam int unsigned ClkDiv    = 4;
  localparam int unsigned CntW      = 12;
  localparam int unsigned Timeout   = 4000;
  localparam int          PosOffset = 1000;
  localparam int          PosMax    = 2047;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            pwm_in = 1'b0;
  logic [CntW-1:0] width_ticks, period_ticks;
  logic [10:0]     pos_val;
  logic            valid, timeout;

  pwm_capture #(
    .CLK_DIV       (ClkDiv),
    .CNT_W         (CntW),
    .POS_OFFSET    (PosOffset),
    .POS_MAX       (PosMax),
    .TIMEOUT_TICKS (Timeout)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_in       (pwm_in),
    .width_ticks  (width_ticks),
    .period_ticks (period_ticks),
    .pos_val      (pos_val),
    .valid        (valid),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w;
    int p;
    int pos;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_valid  = 0;
  int   n_pushed = 0;

  task automatic check_val(input string tag, input int got, input int exp, input int tol = 0);
    n_checks++;
    if (got >= exp - tol && got <= exp + tol) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic int exp_pos(input int w);
    int d;
    d = w - PosOffset;
    if (d < 0) return 0;
    if (d > PosMax) return PosMax;
    return d;
  endfunction

  task automatic push_exp(input int w, input int p);
    exp_t e;
    e.w   = w;
    e.p   = p;
    e.pos = exp_pos(w);
    sb_q.push_back(e);
    n_pushed++;
  endtask

  // Intervals are driven as whole multiples of the tick period.
  task automatic wait_ticks(input int n);
    repeat (n * ClkDiv) @(posedge clk);
    #1;
  endtask

  task automatic rise_edge(input bit closes, input int w, input int p);
    if (closes) push_exp(w, p);
    pwm_in = 1'b1;
  endtask

  task automatic high_low(input int hi, input int lo);
    wait_ticks(hi);
    pwm_in = 1'b0;
    wait_ticks(lo);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_width"}, int'(width_ticks), 0);
    check_val({tag, "_period"}, int'(period_ticks), 0);
    check_val({tag, "_pos"}, int'(pos_val), 0);
    check_val({tag, "_valid"}, int'(valid), 0);
    check_val({tag, "_timeout"}, int'(timeout), 0);
  endtask

  always @(negedge clk) begin
    if (rst && valid) begin
      n_valid++;
      if (sb_q.size() == 0) begin
        check_val("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("width", int'(width_ticks), mon_e.w, 1);
        check_val("period", int'(period_ticks), mon_e.p, 1);
        check_val("pos", int'(pos_val), mon_e.pos,
                  (mon_e.pos == 0 || mon_e.pos == PosMax) ? 0 : 1);
        check_val("timeout_at_valid", int'(timeout), 0);
      end
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not end, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held while the input toggles.
    for (int i = 0; i < 6; i++) begin
      repeat (3) @(posedge clk);
      #1 pwm_in = ~pwm_in;
    end
    @(negedge clk);
    check_idle_outputs("in_reset");
    @(posedge clk);
    #1;
    pwm_in = 1'b0;
    rst    = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_idle_outputs("after_reset");

    // Nominal 1500/3000; first rise opens the run.
    rise_edge(0, 0, 0);
    high_low(1500, 1500);
    rise_edge(1, 1500, 3000);
    high_low(1500, 1500);
    rise_edge(1, 1500, 3000);

    // Third period carries a 3-clk low glitch 700 ticks into the high phase.
    wait_ticks(700);
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
`ifndef GLITCH_FILTER_EN
    push_exp(700, 700);
`endif
    pwm_in = 1'b1;
    repeat (800 * ClkDiv - 3) @(posedge clk);
    #1;
    pwm_in = 1'b0;
    wait_ticks(1500);
`ifdef GLITCH_FILTER_EN
    rise_edge(1, 1500, 3000);
`else
    rise_edge(1, 800, 2300);
`endif

    // Clamp low, then clamp high.
    high_low(600, 100);
    rise_edge(1, 600, 700);
    high_low(3100, 400);
    rise_edge(1, 3100, 3500);

    // Constant high past the timeout threshold.
    wait_ticks(3990);
    check_val("timeout_early", int'(timeout), 0);
    wait_ticks(110);
    check_val("timeout_set", int'(timeout), 1);
    check_val("hold_width", int'(width_ticks), 3100, 1);
    check_val("hold_period", int'(period_ticks), 3500, 1);
    check_val("hold_pos", int'(pos_val), PosMax);

    // Recovery: first rise after timeout is silent, then two clean periods.
    pwm_in = 1'b0;
    wait_ticks(200);
    check_val("timeout_still", int'(timeout), 1);
    rise_edge(0, 0, 0);
    high_low(1000, 1000);
    rise_edge(1, 1000, 2000);
    high_low(1000, 1000);
    rise_edge(1, 1000, 2000);

    repeat (40) @(posedge clk);
    #1;
    check_val("timeout_cleared", int'(timeout), 0);
    check_val("sb_empty", sb_q.size(), 0);
    check_val("valid_count", n_valid, n_pushed);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the servo PWM generator: measures high time and period of an incoming PWM line in 1 us ticks.
- Converts the high time back into the same 11-bit position value the generator consumes (SPI value + 1000 domain).
- Used for loopback self-check of the steering channel and for reading external servo/RC PWM sources.

Parameters:
- CLK_DIV, 100, clk cycles per measurement tick (100 MHz -> 1 us).
- CNT_W, 12, width of tick counters; counters saturate at 2**CNT_W-1.
- POS_OFFSET, 1000, ticks subtracted from high time to form pos_val.
- POS_MAX, 2047, upper clamp of pos_val.
- TIMEOUT_TICKS, 4000, ticks without any edge before timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- pwm_in  in  1  asynchronous PWM input.
- width_ticks  out  CNT_W  high time of last complete period, in ticks.
- period_ticks  out  CNT_W  rise-to-rise time of last complete period, in ticks.
- pos_val  out  11  clamp(width_ticks - POS_OFFSET, 0, POS_MAX).
- valid  out  1  one-clk pulse when the three outputs above update.
- timeout  out  1  level; no edge seen for TIMEOUT_TICKS.

Behaviour:
- Reset (rst=0, async): all outputs 0, FSM to WAIT_RISE, counters and prescaler 0, synchronizer flops 0.
- Input path: 2-flop synchronizer, then 1 flop for edge detect; rise/fall are 1-clk strobes. Edge strobe appears 3 clk after the input change.
- Prescaler: counts 0..CLK_DIV-1 and emits a tick on wrap. It is free-running and is not re-phased on edges, so measurement error is +/-1 tick.
- FSM states:
  - WAIT_RISE: counters idle. On rise, clear hi_cnt and per_cnt and go to MEAS_HIGH. The first rise after reset or timeout never produces valid.
  - MEAS_HIGH: hi_cnt and per_cnt increment per tick. On fall, go to MEAS_LOW.
  - MEAS_LOW: per_cnt increments per tick. On rise, register width_ticks=hi_cnt, period_ticks=per_cnt and pos_val, pulse valid on the next clk, clear hi_cnt and per_cnt, and return to MEAS_HIGH.
- Output latency: valid asserts 1 clk after the rise strobe, i.e. 4 clk after the pwm_in rise.
- Saturation: hi_cnt and per_cnt stop at all-ones and never wrap. A saturated value is still reported if an edge arrives before timeout.
- pos_val arithmetic: compute at CNT_W+1 bits signed. If width_ticks < POS_OFFSET, pos_val=0. If the result exceeds POS_MAX, pos_val=POS_MAX.
- Timeout:
  - idle_cnt clears on any edge and increments per tick.
  - When idle_cnt reaches TIMEOUT_TICKS: timeout=1, FSM to WAIT_RISE, held outputs unchanged.
  - timeout clears on the next valid pulse.
  - A constant-high or constant-low input therefore reports timeout.
- Simultaneous tick and edge in the same clk: the edge wins. The count is captured before the increment, and the counter is then cleared with no increment.
- Reset mid-measurement: partial counts are discarded and no valid is issued.

Optional Feature:
- GLITCH_FILTER_EN defined:
  - A stability filter is inserted after the synchronizer.
  - The filtered level changes only after the raw synchronized input has held its new value for 8 consecutive clk.
  - Pulses shorter than 8 clk are ignored.
  - All latencies increase by 8 clk.
- Undefined: no filter; synchronizer output feeds the edge detector directly.

Decomposition:
- Package pwm_pkg:
  - CNT_W, POS_W=11, default POS_OFFSET, TIMEOUT_TICKS.
  - FSM enum typedef pwm_cap_state_t {WAIT_RISE, MEAS_HIGH, MEAS_LOW}.
- Sub-module pwm_in_cond: synchronizer + optional glitch filter + rise/fall strobes. The top keeps the prescaler, FSM, counters and output registers.

Test Plan (bench uses CLK_DIV=4, TIMEOUT_TICKS=4000):
- Reset: hold rst=0 with pwm_in toggling -> all outputs 0, no valid. Release -> first rise produces no valid.
- Nominal: 3000-tick period, 1500 ticks high, 3 periods -> valid once per period from the 2nd rise; width_ticks=1500+/-1, period_ticks=3000+/-1, pos_val=500+/-1.
- Clamp low: high time 600 ticks -> pos_val=0, width_ticks=600+/-1.
- Clamp high: high time 3100 ticks, period 3500 -> pos_val=2047.
- Timeout: hold pwm_in=1 for 4100 ticks -> timeout=1 at tick 4000 and outputs hold. Then two clean periods of 2000/1000 ticks -> timeout=0 on the first valid, pos_val=0.
- Filter (GLITCH_FILTER_EN): 3-clk low glitch inside a high phase of 1500 ticks -> width_ticks=1500+/-1. Without the macro -> a short width is reported.
